// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Port 0 is the CPU load/store path; port 1 is the UART/debug loader.
// Each grant produces one mem_en strobe, waits MEM_LAT cycles for read
// data, then returns a one-cycle acknowledge to the winning port.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1   // 1..4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             winner;     // port that owns the current transaction
  logic             last;       // most recently granted port
  logic [CNT_W-1:0] cnt;        // remaining memory latency cycles
  logic             grant;
  logic             grant_id;
  logic             data_valid; // mem_rdata is valid at this clock edge

  assign data_valid = (state == WAIT) && (cnt == CNT_W'(1));

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // Arbitration and next-state decode; requests only count while IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant    = 1'b1;
          grant_id = ~last;
        end else if (req0 || req1) begin
          grant    = 1'b1;
          grant_id = req1;
        end
        if (grant) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (data_valid) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, grant capture, latency counter and read capture.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: only control and output flops are reset here; there is no
      // storage array, so the async reset costs nothing on a wide memory.
      winner    <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
    end else begin
      mem_en <= (state_nxt == ISSUE);
      busy   <= (state_nxt != IDLE);
      ack0   <= (state_nxt == ACK) && !winner;
      ack1   <= (state_nxt == ACK) &&  winner;

      // Address/data/we hold between transactions; only a grant changes them.
      if (grant) begin
        winner    <= grant_id;
        last      <= grant_id;
        mem_we    <= grant_id ? we1    : we0;
        mem_addr  <= grant_id ? addr1  : addr0;
        mem_wdata <= grant_id ? wdata1 : wdata0;
      end

      if (state == ISSUE) begin
        cnt <= CNT_W'(MEM_LAT);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Writes share the read timing but never disturb the held read data.
      if (data_valid && !mem_we) begin
        if (winner) rdata1 <= mem_rdata;
        else        rdata0 <= mem_rdata;
      end
    end
  end

endmodule
